// File: rtl/morse_rx_if.sv
// Decoded-character output channel of morse_rx: valid/ready byte stream plus
// the one-cycle overrun and code_err flags.
interface morse_rx_if;
    logic [7:0] ascii_out;
    logic       ascii_valid;
    logic       ascii_ready;
    logic       overrun;
    logic       code_err;

    modport master (output ascii_out, output ascii_valid, output overrun,
                    output code_err, input ascii_ready);
    modport slave  (input ascii_out, input ascii_valid, input overrun,
                    input code_err, output ascii_ready);
endinterface

// File: rtl/morse_rx.sv
// Morse receiver: measures mark/space runs of a synchronized serial line against
// a latched unit length, decodes ITU letters/digits and queues one ASCII byte.
module morse_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ELEMS   = 6
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic [31:0] unit_len,
    input  logic        morse_in,
    morse_rx_if.master  rx
);
    typedef enum logic [1:0] {IDLE, MARK, SPACE, GAP} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   m, m_d, rise, fall;
    logic [31:0]            u;
    logic [34:0]            cnt, t2, t5;
    logic [2:0]             len;
    logic [MAX_ELEMS-1:0]   bits;
    logic                   too_long;
    logic [7:0]             lut, emit_byte, out_q;
    logic                   emit_chr, emit_spc, emit, emit_err, pop;
    logic                   valid_q, overrun_q, err_q;

    function automatic logic [7:0] decode(input logic [2:0] n, input logic [7:0] p);
        case ({n, p})
            {3'd2, 8'b01}:    return 8'h41;  {3'd4, 8'b1000}:  return 8'h42;
            {3'd4, 8'b1010}:  return 8'h43;  {3'd3, 8'b100}:   return 8'h44;
            {3'd1, 8'b0}:     return 8'h45;  {3'd4, 8'b0010}:  return 8'h46;
            {3'd3, 8'b110}:   return 8'h47;  {3'd4, 8'b0000}:  return 8'h48;
            {3'd2, 8'b00}:    return 8'h49;  {3'd4, 8'b0111}:  return 8'h4A;
            {3'd3, 8'b101}:   return 8'h4B;  {3'd4, 8'b0100}:  return 8'h4C;
            {3'd2, 8'b11}:    return 8'h4D;  {3'd2, 8'b10}:    return 8'h4E;
            {3'd3, 8'b111}:   return 8'h4F;  {3'd4, 8'b0110}:  return 8'h50;
            {3'd4, 8'b1101}:  return 8'h51;  {3'd3, 8'b010}:   return 8'h52;
            {3'd3, 8'b000}:   return 8'h53;  {3'd1, 8'b1}:     return 8'h54;
            {3'd3, 8'b001}:   return 8'h55;  {3'd4, 8'b0001}:  return 8'h56;
            {3'd3, 8'b011}:   return 8'h57;  {3'd4, 8'b1001}:  return 8'h58;
            {3'd4, 8'b1011}:  return 8'h59;  {3'd4, 8'b1100}:  return 8'h5A;
            {3'd5, 8'b11111}: return 8'h30;  {3'd5, 8'b01111}: return 8'h31;
            {3'd5, 8'b00111}: return 8'h32;  {3'd5, 8'b00011}: return 8'h33;
            {3'd5, 8'b00001}: return 8'h34;  {3'd5, 8'b00000}: return 8'h35;
            {3'd5, 8'b10000}: return 8'h36;  {3'd5, 8'b11000}: return 8'h37;
            {3'd5, 8'b11100}: return 8'h38;  {3'd5, 8'b11110}: return 8'h39;
            default:          return 8'h3F;
        endcase
    endfunction

    always_comb begin
        m         = sync[SYNC_STAGES-1];
        rise      = m & ~m_d;
        fall      = ~m & m_d;
        t2        = {2'b00, u, 1'b0};
        t5        = {3'b000, u} + {1'b0, u, 2'b00};
        lut       = decode(len, 8'(bits));
        emit_chr  = (state == SPACE) && (cnt == t2);
        emit_spc  = (state == GAP) && (cnt == t5);
        emit      = emit_chr | emit_spc;
        emit_err  = emit_chr && (too_long || lut == 8'h3F);
        emit_byte = emit_spc ? 8'h20 : (too_long ? 8'h3F : lut);
        pop       = valid_q & rx.ascii_ready;
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state     <= IDLE;
            sync      <= '0;
            m_d       <= 1'b0;
            u         <= 32'd1;
            cnt       <= '0;
            len       <= '0;
            bits      <= '0;
            too_long  <= 1'b0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], morse_in};
            m_d       <= m;
            // the edge cycle is the first cycle of the new run, so cnt == run length
            cnt       <= (rise | fall) ? 35'd1 : (&cnt ? cnt : cnt + 35'd1);
            overrun_q <= 1'b0;
            err_q     <= 1'b0;

            case (state)
                IDLE: if (rise) begin
                    state <= MARK;
                    u     <= (unit_len == 32'd0) ? 32'd1 : unit_len;
                end
                MARK: if (fall) begin
                    if (len == 3'(MAX_ELEMS)) too_long <= 1'b1;
                    else begin
                        len  <= len + 3'd1;
                        bits <= {bits[MAX_ELEMS-2:0], cnt >= t2};
                    end
                    state <= SPACE;
                end
                SPACE: if (emit_chr) begin
                    len      <= '0;
                    bits     <= '0;
                    too_long <= 1'b0;
                    state    <= rise ? MARK : GAP;
                end else if (rise) state <= MARK;
                GAP: if (rise) state <= MARK;
                     else if (emit_spc) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (emit) begin
                if (!valid_q || pop) begin
                    out_q   <= emit_byte;
                    valid_q <= 1'b1;
                    err_q   <= emit_err;
                end else overrun_q <= 1'b1;
            end else if (pop) valid_q <= 1'b0;
        end
    end

    assign rx.ascii_out   = out_q;
    assign rx.ascii_valid = valid_q;
    assign rx.overrun     = overrun_q;
    assign rx.code_err    = err_q;
endmodule

// File: tb/tb_morse_rx.sv
// Scoreboard bench for morse_rx: expected bytes queued as Morse is driven,
// popped and compared on every accepted output byte.
module tb_morse_rx;
    logic        clk = 1'b0;
    logic        arst_n;
    logic [31:0] unit_len;
    logic        morse_in;
    int          n_chk = 0, n_fail = 0, n_ovr = 0, n_err = 0;
    logic [7:0]  exp_q[$];

    morse_rx_if rif();

    morse_rx dut (.clk(clk), .arst_n(arst_n), .unit_len(unit_len),
                  .morse_in(morse_in), .rx(rif));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (arst_n) begin
        if (rif.overrun) n_ovr++;
        if (rif.code_err) begin
            n_err++;
            chk("err_byte", 32'(rif.ascii_out), 32'h3F);
        end
        if (rif.ascii_valid && rif.ascii_ready) begin
            if (exp_q.size() == 0) chk("extra_out", 32'(exp_q.size()), 32'd1);
            else chk("byte", 32'(rif.ascii_out), 32'(exp_q.pop_front()));
        end
    end

    task automatic pulse(input int hi, input int lo);
        morse_in = 1'b1;
        repeat (hi) @(negedge clk);
        morse_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 rif.ascii_ready = v;
        @(negedge clk);
    endtask

    task automatic finish_test(input string tag, input int e0, input int o0,
                               input int exp_err, input int exp_ovr);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        repeat (10) @(negedge clk);
        chk({tag, "_code_err"}, 32'(n_err - e0), 32'(exp_err));
        chk({tag, "_overrun"}, 32'(n_ovr - o0), 32'(exp_ovr));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int e0, o0;
        arst_n = 1'b0; unit_len = 32'd4; morse_in = 1'b0; rif.ascii_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_valid", 32'(rif.ascii_valid), 32'd0);
        chk("rst_out", 32'(rif.ascii_out), 32'd0);
        chk("rst_ovr", 32'(rif.overrun), 32'd0);
        chk("rst_err", 32'(rif.code_err), 32'd0);
        arst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 'A'
        e0 = n_err; o0 = n_ovr;
        exp_q.push_back(8'h41); exp_q.push_back(8'h20);
        pulse(4, 4); pulse(12, 40);
        finish_test("A", e0, o0, 0, 0);

        // "ET": char gap exceeds T2 but not T5, so no space in between
        e0 = n_err; o0 = n_ovr;
        exp_q.push_back(8'h45); exp_q.push_back(8'h54); exp_q.push_back(8'h20);
        pulse(4, 12); pulse(12, 40);
        finish_test("ET", e0, o0, 0, 0);

        // dot/dash boundary at T2 = 8
        e0 = n_err; o0 = n_ovr;
        exp_q.push_back(8'h45); exp_q.push_back(8'h20);
        pulse(7, 40);
        exp_q.push_back(8'h54); exp_q.push_back(8'h20);
        pulse(8, 40);
        finish_test("bnd", e0, o0, 0, 0);

        // unit_len 0 acts as 1
        unit_len = 32'd0;
        e0 = n_err; o0 = n_ovr;
        exp_q.push_back(8'h45); exp_q.push_back(8'h20);
        pulse(1, 20);
        finish_test("u0", e0, o0, 0, 0);

        // seven dots overflow the element register; -.-.-. is unknown
        unit_len = 32'd2;
        e0 = n_err; o0 = n_ovr;
        exp_q.push_back(8'h3F); exp_q.push_back(8'h20);
        for (int i = 0; i < 6; i++) pulse(2, 2);
        pulse(2, 40);
        exp_q.push_back(8'h3F); exp_q.push_back(8'h20);
        for (int i = 0; i < 3; i++) begin pulse(4, 2); pulse(2, (i == 2) ? 40 : 2); end
        finish_test("bad", e0, o0, 2, 0);

        // backpressure: 'S' held, 'O' dropped, space after ready returns
        unit_len = 32'd4;
        set_ready(1'b0);
        e0 = n_err; o0 = n_ovr;
        exp_q.push_back(8'h53); exp_q.push_back(8'h20);
        pulse(4, 4); pulse(4, 4); pulse(4, 12);
        pulse(12, 4); pulse(12, 4); pulse(12, 14);
        chk("hold_valid", 32'(rif.ascii_valid), 32'd1);
        chk("hold_byte", 32'(rif.ascii_out), 32'h53);
        set_ready(1'b1);
        repeat (30) @(negedge clk);
        finish_test("bp", e0, o0, 0, 1);

        // reset mid-dash discards the partial character
        e0 = n_err; o0 = n_ovr;
        morse_in = 1'b1;
        repeat (6) @(negedge clk);
        arst_n = 1'b0; morse_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_valid", 32'(rif.ascii_valid), 32'd0);
        chk("mid_rst_out", 32'(rif.ascii_out), 32'd0);
        arst_n = 1'b1;
        repeat (4) @(negedge clk);
        exp_q.push_back(8'h4B); exp_q.push_back(8'h20);
        pulse(12, 4); pulse(4, 4); pulse(12, 40);
        finish_test("K", e0, o0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
